// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and address helpers for the instruction memory arbiter
package imem_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} owner_t;

  localparam int WORD_BYTES = 4;
  localparam int IDX_LSB    = $clog2(WORD_BYTES);

  // Misaligned or beyond the memory window; aw is the word-index width.
  function automatic logic addr_err(input logic [31:0] addr, input int aw);
    return (addr[IDX_LSB-1:0] != '0) || ((addr >> (aw + IDX_LSB)) != 32'd0);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch and loader request/response bundle
interface imem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ld_req;
  logic        ld_we;
  logic        ld_lock;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        ld_err;
  logic        cpu_hold;

  modport master (
    output if_req, if_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  ld_gnt, ld_rvalid, ld_rdata, ld_err, cpu_hold
  );

  modport slave (
    input  if_req, if_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output ld_gnt, ld_rvalid, ld_rdata, ld_err, cpu_hold
  );
endinterface

// File: rtl/imem_sp_ram.sv
// rtl/imem_sp_ram.sv - single-port instruction RAM, synchronous read-first
module imem_sp_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - arbitrates fetch and loader onto one instruction RAM port
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH),
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_arbiter_if.slave bus,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  arb_state_t     state_q, state_d;
  logic [SCW-1:0] starve_q, starve_d;
  owner_t         owner_q, owner_d;
  logic           err_q, err_d;
  logic           we_q, we_d;

  logic           if_gnt, ld_gnt, bad;
  logic [31:0]    sel_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      starve_q <= '0;
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      we_q     <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    owner_d   = OWN_NONE;
    err_d     = 1'b0;
    we_d      = 1'b0;
    if_gnt    = 1'b0;
    ld_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (state_q == LOCKED) begin
      ld_gnt = bus.ld_req;
    end else begin
      ld_gnt = bus.ld_req && !(bus.if_req && starve_q == STARVE_LIM);
      if_gnt = bus.if_req && !ld_gnt;
    end

    sel_addr = ld_gnt ? bus.ld_addr : bus.if_addr;
    bad      = addr_err(sel_addr, AW);

    if (ld_gnt || if_gnt) begin
      owner_d = ld_gnt ? OWN_LD : OWN_IF;
      err_d   = bad;
      we_d    = ld_gnt && bus.ld_we;
      // Faulting requests never reach the RAM, so bad writes are dropped.
      if (!bad) begin
        mem_en    = 1'b1;
        mem_we    = we_d;
        mem_addr  = sel_addr[AW+IDX_LSB-1:IDX_LSB];
        mem_wdata = bus.ld_wdata;
      end
    end

    if (state_q == ARB) begin
      if (if_gnt || !bus.if_req)                starve_d = '0;
      else if (ld_gnt && starve_q != STARVE_LIM) starve_d = starve_q + SCW'(1);
      if (ld_gnt && bus.ld_lock)                state_d = LOCKED;
    end else if (ld_gnt && !bus.ld_lock) begin
      state_d  = ARB;
      starve_d = '0;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ld_gnt    = ld_gnt;
  assign bus.cpu_hold  = (state_q == LOCKED);
  assign bus.if_rvalid = (owner_q == OWN_IF);
  assign bus.ld_rvalid = (owner_q == OWN_LD);
  assign bus.if_err    = (owner_q == OWN_IF) && err_q;
  assign bus.ld_err    = (owner_q == OWN_LD) && err_q;
  assign bus.if_rdata  = ((owner_q == OWN_IF) && !err_q) ? mem_rdata : 32'd0;
  assign bus.ld_rdata  = ((owner_q == OWN_LD) && !err_q && !we_q) ? mem_rdata : 32'd0;
endmodule
